// File: rtl/pbsw_pkg.sv
// Shared types and constants for the push-button/switch LED controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pbsw_pkg;

   // FSM encoding: MODE output is the state bit itself
   typedef enum logic {
      ST_HOLD   = 1'b0,
      ST_ROTATE = 1'b1
   } state_t;

   // Defaults sized for a 100 MHz clock: 1 ms debounce, 0.25 s rotate step
   localparam int DB_CYCLES_DEF = 100000;
   localparam int ROT_DIV_DEF   = 25000000;

   // Counter widths cover 0..DEF-1 of the default settings
   localparam int DB_CNT_W  = $clog2(DB_CYCLES_DEF);
   localparam int ROT_CNT_W = $clog2(ROT_DIV_DEF);

   // Rotate left by one, MSB wraps into LSB
   function automatic logic [7:0] rotl8(input logic [7:0] i_v);
      return {i_v[6:0], i_v[7]};
   endfunction

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, rising-edge pulse.
// Latency: pulse appears DB_CYCLES+3 edges after the first edge sampling a held-high input.
// Backpressure: none; the one-cycle pulse must be consumed on the cycle it is asserted.
module pb_debounce
   import pbsw_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = DB_CNT_W
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after DB_CYCLES consecutive disagreeing samples
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
         r_cnt    <= '0;
      end else if (r_cnt == LP_CNT_MAX) begin
         r_stable <= r_sync2;
         r_cnt    <= '0;
      end else begin
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // One registered pulse per stable 0->1 transition; releases are silent
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stable_d <= 1'b0;
         r_pulse    <= 1'b0;
      end else begin
         r_stable_d <= r_stable;
         r_pulse    <= r_stable & ~r_stable_d;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/pbsw_controller.sv
// LED controller: buttons clear/load/rotate-toggle an 8-bit LED register that can auto-rotate.
// Latency: LED/MODE update one edge after a debounced event pulse (DB_CYCLES+4 from press).
// Backpressure: none; simultaneous events resolve clear > load > toggle, losers are dropped.
module pbsw_controller
   import pbsw_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int ROT_DIV   = ROT_DIV_DEF
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       BTNL,
   input  logic       BTNR,
   input  logic       BTNC,
   input  logic [7:0] SW,
   output logic [7:0] LED,
   output logic       MODE
);

   localparam logic [ROT_CNT_W-1:0] LP_ROT_MAX = ROT_CNT_W'(ROT_DIV - 1);

   logic                 w_evt_load;
   logic                 w_evt_clr;
   logic                 w_evt_tog;
   logic                 w_do_clr;
   logic                 w_do_load;
   logic                 w_do_tog;
   logic                 w_wrap;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [7:0]           r_led;
   logic [7:0]           w_led_nxt;
   logic [ROT_CNT_W-1:0] r_rot_cnt;
   logic [ROT_CNT_W-1:0] w_rot_cnt_nxt;

   pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(DB_CNT_W)) u_db_load (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_btn   (BTNL),
      .o_pulse (w_evt_load)
   );

   pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(DB_CNT_W)) u_db_clr (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_btn   (BTNR),
      .o_pulse (w_evt_clr)
   );

   pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(DB_CNT_W)) u_db_tog (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_btn   (BTNC),
      .o_pulse (w_evt_tog)
   );

   // Priority resolution: a higher-priority event masks the others in the same cycle
   assign w_do_clr  = w_evt_clr;
   assign w_do_load = w_evt_load & ~w_evt_clr;
   assign w_do_tog  = w_evt_tog & ~w_evt_clr & ~w_evt_load;
   assign w_wrap    = (r_state == ST_ROTATE) && (r_rot_cnt == LP_ROT_MAX);

   // FSM state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_HOLD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: clear forces HOLD, toggle flips, load keeps state
   always_comb begin
      w_state_nxt = r_state;
      if (w_do_clr) begin
         w_state_nxt = ST_HOLD;
      end else if (w_do_tog) begin
         w_state_nxt = (r_state == ST_HOLD) ? ST_ROTATE : ST_HOLD;
      end
   end

   // FSM outputs: next LED value and rotate counter; any event pre-empts a rotate step
   always_comb begin
      w_led_nxt     = r_led;
      w_rot_cnt_nxt = r_rot_cnt;
      if (w_do_clr) begin
         w_led_nxt     = 8'h00;
         w_rot_cnt_nxt = '0;
      end else if (w_do_load) begin
         w_led_nxt     = SW;
         w_rot_cnt_nxt = '0;
      end else if (w_do_tog) begin
         w_rot_cnt_nxt = '0;
      end else if (r_state == ST_ROTATE) begin
         if (w_wrap) begin
            w_led_nxt     = rotl8(r_led);
            w_rot_cnt_nxt = '0;
         end else begin
            w_rot_cnt_nxt = r_rot_cnt + ROT_CNT_W'(1);
         end
      end else begin
         w_rot_cnt_nxt = '0;
      end
   end

   // LED and rotate counter registers
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_led     <= 8'h00;
         r_rot_cnt <= '0;
      end else begin
         r_led     <= w_led_nxt;
         r_rot_cnt <= w_rot_cnt_nxt;
      end
   end

   assign LED  = r_led;
   assign MODE = r_state;

endmodule

// File: tb/tb_pbsw_controller.sv
// Directed bench for pbsw_controller with a scoreboard of expected LED/MODE updates.
// Latency: expected updates are timestamped DB_CYCLES+4 edges after the first sampling edge.
// Backpressure: n/a.
module tb_pbsw_controller;

   localparam int DB  = 4;
   localparam int ROT = 8;
   localparam int LAT = DB + 4;

   logic       CLK = 1'b0;
   logic       RSTN;
   logic       BTNL;
   logic       BTNR;
   logic       BTNC;
   logic [7:0] SW;
   logic [7:0] LED;
   logic       MODE;

   typedef struct {
      int         cyc;
      logic [7:0] led;
      logic       mode;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [8:0] prev_out;
   int         clr_pulses = 0;
   int         clr_cyc = -1;

   pbsw_controller #(.DB_CYCLES(DB), .ROT_DIV(ROT)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .BTNL (BTNL),
      .BTNR (BTNR),
      .BTNC (BTNC),
      .SW   (SW),
      .LED  (LED),
      .MODE (MODE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_upd(input int c, input logic [7:0] l, input logic m);
      exp_t e;
      e.cyc  = c;
      e.led  = l;
      e.mode = m;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   // Output monitor: every LED/MODE change outside reset must match the next scoreboard entry
   always @(negedge CLK) begin
      if (!RSTN) begin
         prev_out = {LED, MODE};
      end else begin
         if ({LED, MODE} !== prev_out) begin
            if (sb.size() == 0) begin
               check("unexpected_update", {23'd0, LED, MODE}, {23'd0, prev_out});
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("upd_cycle", cyc, e.cyc);
               check("upd_led", {24'd0, LED}, {24'd0, e.led});
               check("upd_mode", {31'd0, MODE}, {31'd0, e.mode});
            end
            prev_out = {LED, MODE};
         end
         if (dut.w_evt_clr) begin
            clr_pulses++;
            clr_cyc = cyc;
         end
      end
   end

   initial begin
      int c;
      RSTN = 1'b0;
      BTNL = 1'b0;
      BTNR = 1'b0;
      BTNC = 1'b0;
      SW   = 8'h00;
      tick(2);
      check("rst_led", {24'd0, LED}, 32'h00);
      check("rst_mode", {31'd0, MODE}, 32'h0);
      RSTN = 1'b1;
      tick(3);

      // Load A5 with a long press: one update, exact latency, MODE stays 0
      SW   = 8'hA5;
      BTNL = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'hA5, 1'b0);
      tick(20);
      BTNL = 1'b0;
      tick(15);
      check("load_pending", sb.size(), 0);
      check("load_led", {24'd0, LED}, 32'hA5);
      check("load_mode", {31'd0, MODE}, 32'h0);

      // Glitchy load button never reaches a stable level
      SW = 8'h3C;
      repeat (5) begin
         BTNL = 1'b1;
         tick(3);
         BTNL = 1'b0;
         tick(1);
      end
      tick(15);
      check("glitch_led", {24'd0, LED}, 32'hA5);

      // Load 81, rotate twice, then toggle back to HOLD mid-count
      SW   = 8'h81;
      BTNL = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'h81, 1'b0);
      tick(10);
      BTNL = 1'b0;
      tick(15);
      BTNC = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'h81, 1'b1);
      expect_upd(c + LAT + ROT, 8'h03, 1'b1);
      expect_upd(c + LAT + 2 * ROT, 8'h06, 1'b1);
      expect_upd(c + 20 + LAT, 8'h06, 1'b0);
      tick(5);
      BTNC = 1'b0;
      tick(15);
      BTNC = 1'b1;
      tick(5);
      BTNC = 1'b0;
      tick(30);
      check("rot_pending", sb.size(), 0);
      check("rot_frozen_led", {24'd0, LED}, 32'h06);
      check("rot_frozen_mode", {31'd0, MODE}, 32'h0);

      // All three buttons together: clear wins, load and toggle dropped
      SW   = 8'hFF;
      BTNL = 1'b1;
      BTNR = 1'b1;
      BTNC = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'h00, 1'b0);
      tick(10);
      BTNL = 1'b0;
      BTNR = 1'b0;
      BTNC = 1'b0;
      tick(15);
      check("prio_clr_pending", sb.size(), 0);
      check("prio_clr_led", {24'd0, LED}, 32'h00);
      check("prio_clr_mode", {31'd0, MODE}, 32'h0);

      // Load and toggle together: load wins, toggle dropped
      SW   = 8'h3C;
      BTNL = 1'b1;
      BTNC = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'h3C, 1'b0);
      tick(10);
      BTNL = 1'b0;
      BTNC = 1'b0;
      tick(15);
      check("prio_load_pending", sb.size(), 0);
      check("prio_load_mode", {31'd0, MODE}, 32'h0);

      // Reset mid-rotate aborts immediately and stays in HOLD afterwards
      BTNC = 1'b1;
      c    = cyc;
      expect_upd(c + LAT, 8'h3C, 1'b1);
      expect_upd(c + LAT + ROT, 8'h78, 1'b1);
      tick(5);
      BTNC = 1'b0;
      tick(15);
      check("rot2_pending", sb.size(), 0);
      RSTN = 1'b0;
      #1;
      check("midrst_led", {24'd0, LED}, 32'h00);
      check("midrst_mode", {31'd0, MODE}, 32'h0);
      tick(1);
      RSTN = 1'b1;
      tick(30);
      check("postrst_led", {24'd0, LED}, 32'h00);
      check("postrst_mode", {31'd0, MODE}, 32'h0);

      // Clear button held through reset release: exactly one clear event after a full debounce
      BTNR = 1'b1;
      tick(1);
      RSTN = 1'b0;
      tick(2);
      RSTN       = 1'b1;
      c          = cyc;
      clr_pulses = 0;
      clr_cyc    = -1;
      tick(15);
      BTNR = 1'b0;
      tick(15);
      check("held_clr_count", clr_pulses, 1);
      check("held_clr_cycle", clr_cyc, c + LAT - 1);
      check("held_clr_led", {24'd0, LED}, 32'h00);
      check("held_clr_mode", {31'd0, MODE}, 32'h0);
      check("final_pending", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pbsw_controller.md
PBSW_CONTROLLER -- requirements
Module: pbsw_controller

Interface
REQ-001 Parameter DB_CYCLES, default 100000: number of consecutive stable samples needed to accept a button level (1 ms at 100 MHz).
REQ-002 Parameter ROT_DIV, default 25000000: number of clock cycles between rotate steps (0.25 s at 100 MHz).
REQ-003 CLK  input  1  system clock, rising-edge active; this is the only clock.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 BTNL  input  1  raw push button (load), asynchronous to CLK, active-high.
REQ-006 BTNR  input  1  raw push button (clear), asynchronous to CLK, active-high.
REQ-007 BTNC  input  1  raw push button (rotate toggle), asynchronous to CLK, active-high.
REQ-008 SW  input  8  slide switch data, quasi-static, sampled only on a load event.
REQ-009 LED  output  8  displayed data, driven directly from a register.
REQ-010 MODE  output  1  1 = ROTATE state, 0 = HOLD state; driven directly from a register.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a debouncer.
REQ-012 Debouncer: the stable level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any agreeing sample resets the count to 0.
REQ-013 A one-cycle event pulse is generated on each stable 0->1 transition; a stable 1->0 transition generates no event.
REQ-014 A held button generates exactly one event; no auto-repeat.
REQ-015 Latency: LED/MODE update on the clock edge immediately following the event pulse. Total latency from the first edge that samples raw high is DB_CYCLES+4 edges.
REQ-016 FSM states: HOLD (LED static) and ROTATE (LED rotates left by 1 every ROT_DIV cycles; LED[7] wraps into LED[0]).
REQ-017 Clear event: LED <= 8'h00; FSM -> HOLD; rotate counter <= 0.
REQ-018 Load event: LED <= SW; FSM state unchanged; rotate counter <= 0.
REQ-019 Rotate-toggle event: HOLD -> ROTATE or ROTATE -> HOLD; rotate counter <= 0; LED unchanged on that edge.
REQ-020 Simultaneous events in one cycle: priority is clear > load > toggle; lower-priority events in that cycle are discarded, not queued.
REQ-021 Rotate counter runs only in ROTATE; it counts 0..ROT_DIV-1 and wraps to 0. The rotate step occurs on the edge where it wraps.
REQ-022 If an event and a rotate step fall on the same edge, the event wins and the step is skipped.
REQ-023 Rotating 8'h00 or 8'hFF leaves LED unchanged; no special case.

Reset
REQ-024 While RSTN=0: LED=8'h00, MODE=0, FSM=HOLD, all synchronizer/stable flops=0, all counters=0, no event pending.
REQ-025 Reset asserted mid-debounce or mid-rotate aborts the operation immediately. After release, a button already held is accepted as a new press once it completes a full DB_CYCLES debounce.

Structure
REQ-026 Shared package pbsw_pkg holds the state encoding (HOLD=0, ROTATE=1), the default values of DB_CYCLES and ROT_DIV, and the counter widths derived from those defaults.
REQ-027 One sub-module, pb_debounce (synchronizer + debounce counter + rising-edge pulse), is instantiated three times; FSM, LED register and rotate counter live in the top level.

Verification (DB_CYCLES=4, ROT_DIV=8)
REQ-028 SW=8'hA5, BTNL high for 20 cycles -> LED=8'hA5 exactly DB_CYCLES+4 edges after the press; exactly one update; MODE stays 0.
REQ-029 BTNL glitches (high 3 cycles, low 1, repeated) -> LED never changes.
REQ-030 LED=8'h81, BTNC pressed -> MODE=1; after 8 cycles LED=8'h03; after another 8 cycles LED=8'h06; second BTNC press -> MODE=0 and LED freezes.
REQ-031 BTNL and BTNR rise on the same edge with SW=8'hFF -> LED=8'h00, MODE=0.
REQ-032 In ROTATE, drop RSTN for 1 cycle mid-count -> LED=8'h00 and MODE=0 immediately; no rotate step occurs until a new BTNC press.
REQ-033 BTNR held through reset release -> LED remains 8'h00; one clear event occurs DB_CYCLES+4 edges after release.
